// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the camera-to-VGA pixel FIFO: syncs the Gray write pointer, owns the read pointer, gates reads per frame.
// Latency: r_en/pix_valid are combinational (0-cycle read); a write reaches empty/rd_level 3 rclk edges later.
// Backpressure: none upstream; reads only in STREAM while non-empty, a request while empty sets sticky underrun.
module fifo_rd_ctrl #(
    parameter int PTR_WIDTH = 10,
    parameter int PREFILL   = 256
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [PTR_WIDTH:0]   g_wptr,
    input  logic                 frame_start,
    input  logic                 pix_req,
    output logic                 r_en,
    output logic [PTR_WIDTH:0]   b_rptr,
    output logic [PTR_WIDTH:0]   g_rptr,
    output logic                 empty,
    output logic [PTR_WIDTH:0]   rd_level,
    output logic                 pix_valid,
    output logic                 underrun,
    output logic                 streaming
);

    typedef enum logic [1:0] {ST_IDLE, ST_PREFILL, ST_STREAM} state_t;

    localparam logic [PTR_WIDTH:0] PREFILL_LVL = (PTR_WIDTH+1)'(PREFILL);

    state_t               state_q, state_d;
    logic [PTR_WIDTH:0]   wq1_gptr_q, wq2_gptr_q;
    logic [PTR_WIDTH:0]   wq2_bptr;
    logic [PTR_WIDTH:0]   b_rptr_q, b_rptr_d;
    logic [PTR_WIDTH:0]   g_rptr_q, g_rptr_d;
    logic [PTR_WIDTH:0]   rd_level_q, rd_level_d;
    logic                 empty_q, empty_d;
    logic                 underrun_q, underrun_d;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // frame_start restarts prefill from any state and wins over the stream decision
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = ST_PREFILL;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_IDLE;
                ST_PREFILL: if (rd_level_q >= PREFILL_LVL) state_d = ST_STREAM;
                ST_STREAM:  state_d = ST_STREAM;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        streaming = (state_q == ST_STREAM);
        r_en      = streaming & pix_req & ~empty_q;
        pix_valid = r_en;
    end

    // Each binary bit is the XOR of all Gray bits from the MSB down to it
    always_comb begin
        wq2_bptr = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            wq2_bptr[i] = ^(wq2_gptr_q >> i);
        end
    end

    always_comb begin
        b_rptr_d   = b_rptr_q + {{PTR_WIDTH{1'b0}}, r_en};
        g_rptr_d   = b_rptr_d ^ (b_rptr_d >> 1);
        empty_d    = (g_rptr_d == wq2_gptr_q);
        rd_level_d = wq2_bptr - b_rptr_d;
        underrun_d = underrun_q;
        if (frame_start) begin
            underrun_d = 1'b0;
        end else if (streaming && pix_req && empty_q) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            wq1_gptr_q <= '0;
            wq2_gptr_q <= '0;
            b_rptr_q   <= '0;
            g_rptr_q   <= '0;
            rd_level_q <= '0;
            empty_q    <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            wq1_gptr_q <= g_wptr;
            wq2_gptr_q <= wq1_gptr_q;
            b_rptr_q   <= b_rptr_d;
            g_rptr_q   <= g_rptr_d;
            rd_level_q <= rd_level_d;
            empty_q    <= empty_d;
            underrun_q <= underrun_d;
        end
    end

    assign b_rptr   = b_rptr_q;
    assign g_rptr   = g_rptr_q;
    assign empty    = empty_q;
    assign rd_level = rd_level_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with PTR_WIDTH=4, PREFILL=8.
module tb_fifo_rd_ctrl;

    localparam int PW = 4;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic [PW:0]   g_wptr = '0;
    logic          frame_start = 1'b0;
    logic          pix_req = 1'b0;
    logic          r_en;
    logic [PW:0]   b_rptr;
    logic [PW:0]   g_rptr;
    logic          empty;
    logic [PW:0]   rd_level;
    logic          pix_valid;
    logic          underrun;
    logic          streaming;

    int total = 0;
    int bad   = 0;
    logic [PW:0] wcnt = '0;

    fifo_rd_ctrl #(.PTR_WIDTH(PW), .PREFILL(8)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .g_wptr(g_wptr), .frame_start(frame_start),
        .pix_req(pix_req), .r_en(r_en), .b_rptr(b_rptr), .g_rptr(g_rptr),
        .empty(empty), .rd_level(rd_level), .pix_valid(pix_valid),
        .underrun(underrun), .streaming(streaming)
    );

    always #5 rclk = ~rclk;

    function automatic logic [PW:0] gray(input logic [PW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic test_reset;
        rrst_n = 1'b0; pix_req = 1'b1; frame_start = 1'b0; g_wptr = '0;
        #12;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", empty); end
        total++; if (rd_level !== 5'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", rd_level); end
        total++; if (r_en !== 1'b0) begin bad++; $display("FAIL rst_ren: got %b want 0", r_en); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_pv: got %b want 0", pix_valid); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        total++; if (streaming !== 1'b0) begin bad++; $display("FAIL rst_streaming: got %b want 0", streaming); end
        total++; if (b_rptr !== 5'd0 || g_rptr !== 5'd0) begin bad++; $display("FAIL rst_ptrs: got %0d/%0d want 0/0", b_rptr, g_rptr); end
        @(negedge rclk) rrst_n = 1'b1;
        repeat (4) begin
            @(posedge rclk); #1;
            @(negedge rclk);
            total++; if (r_en !== 1'b0 || underrun !== 1'b0) begin bad++; $display("FAIL idle_quiet: got r_en=%b underrun=%b want 0/0", r_en, underrun); end
        end
        pix_req = 1'b0;
    endtask

    // Writes 1..8 one per cycle; rd_level trails the driven pointer by 3 edges
    task automatic test_prefill;
        logic [PW:0] wh [0:11];
        logic [PW:0] exp_lvl;
        @(posedge rclk); #1 frame_start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge rclk); #1;
            frame_start = 1'b0;
            if (c < 8) wcnt = wcnt + 5'd1;
            wh[c]   = wcnt;
            g_wptr  = gray(wcnt);
            pix_req = (c < 4);
            @(negedge rclk);
            exp_lvl = (c >= 3) ? wh[c-3] : 5'd0;
            total++; if (rd_level !== exp_lvl) begin bad++; $display("FAIL prefill_level c=%0d: got %0d want %0d", c, rd_level, exp_lvl); end
            total++; if (streaming !== (c >= 11)) begin bad++; $display("FAIL prefill_streaming c=%0d: got %b want %b", c, streaming, c >= 11); end
            total++; if (r_en !== 1'b0 || underrun !== 1'b0) begin bad++; $display("FAIL prefill_quiet c=%0d: got r_en=%b underrun=%b want 0/0", c, r_en, underrun); end
        end
    endtask

    task automatic test_stream_to_empty;
        for (int k = 0; k < 10; k++) begin
            @(posedge rclk); #1 pix_req = 1'b1;
            @(negedge rclk);
            total++; if (r_en !== (k < 8) || pix_valid !== (k < 8)) begin bad++; $display("FAIL drain_ren k=%0d: got %b/%b want %b", k, r_en, pix_valid, k < 8); end
            total++; if (b_rptr !== 5'((k < 8) ? k : 8)) begin bad++; $display("FAIL drain_rptr k=%0d: got %0d want %0d", k, b_rptr, (k < 8) ? k : 8); end
            total++; if (empty !== (k >= 8)) begin bad++; $display("FAIL drain_empty k=%0d: got %b want %b", k, empty, k >= 8); end
            total++; if (rd_level !== 5'((k < 8) ? 8 - k : 0)) begin bad++; $display("FAIL drain_level k=%0d: got %0d want %0d", k, rd_level, (k < 8) ? 8 - k : 0); end
            total++; if (underrun !== (k >= 9)) begin bad++; $display("FAIL drain_underrun k=%0d: got %b want %b", k, underrun, k >= 9); end
        end
    endtask

    task automatic test_frame_start;
        @(posedge rclk); #1 pix_req = 1'b1; frame_start = 1'b1;
        @(negedge rclk);
        total++; if (r_en !== 1'b0) begin bad++; $display("FAIL fs_ren: got %b want 0", r_en); end
        @(posedge rclk); #1 frame_start = 1'b0;
        @(negedge rclk);
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL fs_underrun: got %b want 0", underrun); end
        total++; if (streaming !== 1'b0) begin bad++; $display("FAIL fs_streaming: got %b want 0", streaming); end
        total++; if (b_rptr !== 5'd8 || g_rptr !== gray(5'd8)) begin bad++; $display("FAIL fs_ptrs: got %0d/%0d want 8/%0d", b_rptr, g_rptr, gray(5'd8)); end
        @(posedge rclk); #1;
        @(negedge rclk);
        total++; if (underrun !== 1'b0 || r_en !== 1'b0) begin bad++; $display("FAIL fs_prefill_ignores_req: got underrun=%b r_en=%b want 0/0", underrun, r_en); end
        pix_req = 1'b0;
    endtask

    // Refill to 8 then read and write one word per cycle across both pointer wraps
    task automatic test_wrap;
        bit seen;
        logic [PW:0] prev_g;
        logic [PW:0] exp_b;
        logic [PW:0] exp_lvl;
        for (int i = 0; i < 8; i++) begin
            @(posedge rclk); #1 wcnt = wcnt + 5'd1; g_wptr = gray(wcnt);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge rclk); #1;
            @(negedge rclk);
            if (streaming === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL wrap_stream_start: got streaming=%b want 1 within 10 cycles", streaming); end
        total++; if (rd_level !== 5'd8) begin bad++; $display("FAIL wrap_start_level: got %0d want 8", rd_level); end
        prev_g = gray(5'd8);
        for (int n = 0; n < 40; n++) begin
            @(posedge rclk); #1;
            pix_req = 1'b1;
            wcnt    = wcnt + 5'd1;
            g_wptr  = gray(wcnt);
            @(negedge rclk);
            exp_b   = 5'(8 + n);
            exp_lvl = (n < 3) ? 5'(8 - n) : 5'd6;
            total++; if (r_en !== 1'b1) begin bad++; $display("FAIL wrap_ren n=%0d: got %b want 1", n, r_en); end
            total++; if (b_rptr !== exp_b) begin bad++; $display("FAIL wrap_rptr n=%0d: got %0d want %0d", n, b_rptr, exp_b); end
            total++; if (g_rptr !== gray(exp_b)) begin bad++; $display("FAIL wrap_gray n=%0d: got %0d want %0d", n, g_rptr, gray(exp_b)); end
            total++; if (rd_level !== exp_lvl) begin bad++; $display("FAIL wrap_level n=%0d: got %0d want %0d", n, rd_level, exp_lvl); end
            if (n > 0) begin
                total++; if ($countones(g_rptr ^ prev_g) != 1) begin bad++; $display("FAIL wrap_gray_step n=%0d: got %0d bits changed want 1", n, $countones(g_rptr ^ prev_g)); end
            end
            prev_g = g_rptr;
        end
    endtask

    task automatic test_reset_mid_stream;
        bit seen;
        @(posedge rclk); #3 rrst_n = 1'b0;
        #1;
        total++; if (b_rptr !== 5'd0 || r_en !== 1'b0) begin bad++; $display("FAIL mid_rst_async: got b_rptr=%0d r_en=%b want 0/0", b_rptr, r_en); end
        total++; if (empty !== 1'b1 || rd_level !== 5'd0 || streaming !== 1'b0) begin bad++; $display("FAIL mid_rst_state: got empty=%b level=%0d streaming=%b want 1/0/0", empty, rd_level, streaming); end
        wcnt = '0; g_wptr = '0;
        @(negedge rclk) rrst_n = 1'b1;
        repeat (3) begin
            @(posedge rclk); #1;
            @(negedge rclk);
            total++; if (r_en !== 1'b0) begin bad++; $display("FAIL mid_rst_no_read: got %b want 0", r_en); end
        end
        @(posedge rclk); #1 frame_start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge rclk); #1 frame_start = 1'b0; wcnt = wcnt + 5'd1; g_wptr = gray(wcnt);
            @(negedge rclk);
            total++; if (r_en !== 1'b0) begin bad++; $display("FAIL mid_rst_prefill_read i=%0d: got %b want 0", i, r_en); end
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge rclk); #1;
            @(negedge rclk);
            if (streaming === 1'b1) begin
                seen = 1'b1;
                total++; if (r_en !== 1'b1 || b_rptr !== 5'd0) begin bad++; $display("FAIL mid_rst_first_read: got r_en=%b b_rptr=%0d want 1/0", r_en, b_rptr); end
            end else begin
                total++; if (r_en !== 1'b0) begin bad++; $display("FAIL mid_rst_early_read: got %b want 0", r_en); end
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_rst_restream: got streaming=%b want 1 within 10 cycles", streaming); end
        pix_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_stream_to_empty();
        test_frame_start();
        test_wrap();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
